lyte_nonce_dispatcher: RTL and testbench

//  Work scheduler between the job controller and NUM_CORES lyte_miner_core instances.

---
 rtl/lyte_nonce_dispatcher_if.sv | 43 ++++
 rtl/lyte_nonce_dispatcher.sv | 155 +++++++++++++++
 tb/tb_lyte_nonce_dispatcher.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lyte_nonce_dispatcher_if.sv
// ---------------------------------------------------------------------------
// lyte_nonce_dispatcher_if
//   Bundles the job-controller commands, the per-core request/grant handshake
//   and the dispatcher status outputs into one interface.
//
//   master : job controller / core side (drives commands and requests)
//   slave  : the dispatcher itself (drives grants and status)
//
//   job_start, job_abort, job_id, core_solved  : job control commands
//   core_req[NUM_CORES]                        : per-core chunk requests (level)
//   core_grant[NUM_CORES]                      : one-hot grant pulse
//   grant_nonce_start / grant_nonce_end        : inclusive nonce range of grant
//   grant_job_id                               : job tag attached to the grant
//   busy, exhausted, chunks_issued             : dispatcher status
// ---------------------------------------------------------------------------
interface lyte_nonce_dispatcher_if #(
    parameter int NUM_CORES = 8
);
    logic                 job_start;
    logic                 job_abort;
    logic [7:0]           job_id;
    logic                 core_solved;
    logic [NUM_CORES-1:0] core_req;
    logic [NUM_CORES-1:0] core_grant;
    logic [31:0]          grant_nonce_start;
    logic [31:0]          grant_nonce_end;
    logic [7:0]           grant_job_id;
    logic                 busy;
    logic                 exhausted;
    logic [31:0]          chunks_issued;

    modport master (
        output job_start, job_abort, job_id, core_solved, core_req,
        input  core_grant, grant_nonce_start, grant_nonce_end, grant_job_id,
        input  busy, exhausted, chunks_issued
    );

    modport slave (
        input  job_start, job_abort, job_id, core_solved, core_req,
        output core_grant, grant_nonce_start, grant_nonce_end, grant_job_id,
        output busy, exhausted, chunks_issued
    );
endinterface

// File: rtl/lyte_nonce_dispatcher.sv
// ---------------------------------------------------------------------------
// lyte_nonce_dispatcher
//   Hands out fixed-size nonce chunks (2**CHUNK_W nonces each) to NUM_CORES
//   miner cores with round-robin arbitration. Each job walks the 32-bit nonce
//   space exactly once, stopping on solution, abort or exhaustion.
//
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of lyte_nonce_dispatcher_if (commands, core
//            request/grant handshake, grant payload and status)
// ---------------------------------------------------------------------------
module lyte_nonce_dispatcher #(
    parameter int NUM_CORES = 8,
    parameter int CHUNK_W   = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    lyte_nonce_dispatcher_if.slave bus
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CNT_W = 33 - CHUNK_W;

    // Chunk count at which the whole nonce space has been handed out.
    localparam logic [CNT_W-1:0] CHUNK_LIMIT = {1'b1, {(32 - CHUNK_W){1'b0}}};
    localparam logic [31:0]      CHUNK_MASK  = 32'((64'd1 << CHUNK_W) - 64'd1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DISPATCH  = 2'd1,
        EXHAUSTED = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [PTR_W-1:0]     rr_q, rr_d;
    logic [CNT_W-1:0]     chunk_q, chunk_d;
    logic [7:0]           tag_q, tag_d;
    logic [NUM_CORES-1:0] grant_q, grant_d;
    logic [31:0]          start_q, start_d;
    logic [31:0]          end_q, end_d;
    logic [7:0]           gjid_q, gjid_d;
    logic [31:0]          issued_q, issued_d;

    logic [NUM_CORES-1:0] eligible;
    logic [NUM_CORES-1:0] winnerOneHot;
    logic [PTR_W-1:0]     winnerIdx;
    logic [PTR_W-1:0]     hiIdx, loIdx;
    logic                 hiFound, loFound;
    logic [CNT_W-1:0]     chunkNext;
    logic [31:0]          chunkBase;

    // Round-robin pick. The core granted last cycle is masked so it cannot
    // win again before it has had a chance to drop its request. The first
    // eligible core at or after rr_q wins; otherwise wrap to the lowest one.
    always_comb begin
        eligible     = bus.core_req & ~grant_q;
        hiFound      = 1'b0;
        loFound      = 1'b0;
        hiIdx        = '0;
        loIdx        = '0;
        winnerOneHot = '0;
        for (int j = 0; j < NUM_CORES; j++) begin
            if (eligible[j] && !loFound) begin
                loFound = 1'b1;
                loIdx   = PTR_W'(j);
            end
            if (eligible[j] && !hiFound && (j >= int'(rr_q))) begin
                hiFound = 1'b1;
                hiIdx   = PTR_W'(j);
            end
        end
        winnerIdx = hiFound ? hiIdx : loIdx;
        for (int j = 0; j < NUM_CORES; j++) begin
            winnerOneHot[j] = (PTR_W'(j) == winnerIdx);
        end
    end

    // Chunks are aligned, so the upper counter bits form the chunk base
    // directly. The extra counter MSB only flags exhaustion.
    assign chunkNext = chunk_q + CNT_W'(1);
    assign chunkBase = {chunk_q[CNT_W-2:0], {CHUNK_W{1'b0}}};

    // Next-state logic. Commands are prioritised abort > start > solved;
    // a grant is only issued in DISPATCH on a command-free cycle.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        chunk_d  = chunk_q;
        tag_d    = tag_q;
        grant_d  = '0;
        start_d  = start_q;
        end_d    = end_q;
        gjid_d   = gjid_q;
        issued_d = issued_q;

        if (bus.job_abort) begin
            state_d = IDLE;
        end else if (bus.job_start) begin
            state_d  = DISPATCH;
            chunk_d  = '0;
            issued_d = '0;
            tag_d    = bus.job_id;
            rr_d     = '0;
        end else if (bus.core_solved && (state_q != IDLE)) begin
            state_d = IDLE;
        end else if ((state_q == DISPATCH) && loFound) begin
            grant_d = winnerOneHot;
            start_d = chunkBase;
            end_d   = chunkBase | CHUNK_MASK;
            gjid_d  = tag_q;
            rr_d    = (winnerIdx == PTR_W'(NUM_CORES - 1)) ? '0 : winnerIdx + PTR_W'(1);
            chunk_d = chunkNext;
            if (issued_q != 32'hFFFF_FFFF) begin
                issued_d = issued_q + 32'd1;
            end
            if (chunkNext == CHUNK_LIMIT) begin
                state_d = EXHAUSTED;
            end
        end
    end

    // State and output registers. Reset drops any in-flight grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_q     <= '0;
            chunk_q  <= '0;
            tag_q    <= '0;
            grant_q  <= '0;
            start_q  <= '0;
            end_q    <= '0;
            gjid_q   <= '0;
            issued_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            chunk_q  <= chunk_d;
            tag_q    <= tag_d;
            grant_q  <= grant_d;
            start_q  <= start_d;
            end_q    <= end_d;
            gjid_q   <= gjid_d;
            issued_q <= issued_d;
        end
    end

    assign bus.core_grant        = grant_q;
    assign bus.grant_nonce_start = start_q;
    assign bus.grant_nonce_end   = end_q;
    assign bus.grant_job_id      = gjid_q;
    assign bus.busy              = (state_q == DISPATCH);
    assign bus.exhausted         = (state_q == EXHAUSTED);
    assign bus.chunks_issued     = issued_q;

endmodule

// File: tb/tb_lyte_nonce_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_lyte_nonce_dispatcher
//   Directed bench for lyte_nonce_dispatcher. Instance A uses 8 cores with
//   64K-nonce chunks; instance B uses one core with 2**28-nonce chunks so a
//   whole job (16 chunks) can be exhausted. Expected grants are queued when
//   the stimulus is applied and popped whenever a DUT grant pulse is seen.
// ---------------------------------------------------------------------------
module tb_lyte_nonce_dispatcher;

    logic clk;
    logic rst_n;

    lyte_nonce_dispatcher_if #(.NUM_CORES(8)) ifA ();
    lyte_nonce_dispatcher_if #(.NUM_CORES(1)) ifB ();

    lyte_nonce_dispatcher #(.NUM_CORES(8), .CHUNK_W(16)) dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifA.slave)
    );

    lyte_nonce_dispatcher #(.NUM_CORES(1), .CHUNK_W(28)) dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifB.slave)
    );

    typedef struct {
        logic [63:0] grant;
        logic [31:0] nStart;
        logic [31:0] nEnd;
        logic [7:0]  jid;
        logic [31:0] issued;
    } grantExp_t;

    grantExp_t qA[$];
    grantExp_t qB[$];

    int evaluated = 0;
    int failures  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every comparison in the bench funnels through here.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        evaluated++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit toB, input logic start, input logic abort,
                                 input logic solved, input logic [7:0] jid,
                                 input logic [7:0] req);
        if (toB) begin
            ifB.job_start   = start;
            ifB.job_abort   = abort;
            ifB.core_solved = solved;
            ifB.job_id      = jid;
            ifB.core_req    = req[0];
        end else begin
            ifA.job_start   = start;
            ifA.job_abort   = abort;
            ifA.core_solved = solved;
            ifA.job_id      = jid;
            ifA.core_req    = req;
        end
    endtask

    task automatic pushA(input int core, input int k, input logic [7:0] jid);
        grantExp_t e;
        e.grant  = 64'd1 << core;
        e.nStart = 32'(k) << 16;
        e.nEnd   = (32'(k) << 16) + 32'h0000_FFFF;
        e.jid    = jid;
        e.issued = 32'(k + 1);
        qA.push_back(e);
    endtask

    task automatic pushB(input int k, input logic [7:0] jid);
        grantExp_t e;
        e.grant  = 64'd1;
        e.nStart = 32'(k) << 28;
        e.nEnd   = (32'(k) << 28) + 32'h0FFF_FFFF;
        e.jid    = jid;
        e.issued = 32'(k + 1);
        qB.push_back(e);
    endtask

    task automatic monitorA();
        grantExp_t e;
        if (ifA.core_grant !== '0) begin
            if (qA.size() == 0) begin
                checkOutput("A_unexpected_grant", 64'(ifA.core_grant), 64'd0);
            end else begin
                e = qA.pop_front();
                checkOutput("A_grant",  64'(ifA.core_grant), e.grant);
                checkOutput("A_start",  64'(ifA.grant_nonce_start), 64'(e.nStart));
                checkOutput("A_end",    64'(ifA.grant_nonce_end), 64'(e.nEnd));
                checkOutput("A_jobid",  64'(ifA.grant_job_id), 64'(e.jid));
                checkOutput("A_issued", 64'(ifA.chunks_issued), 64'(e.issued));
            end
        end
    endtask

    task automatic monitorB();
        grantExp_t e;
        if (ifB.core_grant !== '0) begin
            if (qB.size() == 0) begin
                checkOutput("B_unexpected_grant", 64'(ifB.core_grant), 64'd0);
            end else begin
                e = qB.pop_front();
                checkOutput("B_grant",  64'(ifB.core_grant), e.grant);
                checkOutput("B_start",  64'(ifB.grant_nonce_start), 64'(e.nStart));
                checkOutput("B_end",    64'(ifB.grant_nonce_end), 64'(e.nEnd));
                checkOutput("B_jobid",  64'(ifB.grant_job_id), 64'(e.jid));
                checkOutput("B_issued", 64'(ifB.chunks_issued), 64'(e.issued));
            end
        end
    endtask

    // One clock: let the DUT take an edge, then sample on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        monitorA();
        monitorB();
    endtask

    task automatic expectDrained(input string tag);
        checkOutput(tag, 64'(qA.size() + qB.size()), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01);

        // Reset with every request asserted: nothing may be granted.
        tick();
        tick();
        checkOutput("rst_A_grant",  64'(ifA.core_grant), 64'd0);
        checkOutput("rst_A_busy",   64'(ifA.busy), 64'd0);
        checkOutput("rst_A_exh",    64'(ifA.exhausted), 64'd0);
        checkOutput("rst_A_issued", 64'(ifA.chunks_issued), 64'd0);
        checkOutput("rst_A_start",  64'(ifA.grant_nonce_start), 64'd0);
        checkOutput("rst_A_end",    64'(ifA.grant_nonce_end), 64'd0);
        checkOutput("rst_A_jobid",  64'(ifA.grant_job_id), 64'd0);
        checkOutput("rst_B_grant",  64'(ifB.core_grant), 64'd0);
        checkOutput("rst_B_busy",   64'(ifB.busy), 64'd0);

        rst_n = 1'b1;
        repeat (3) tick();
        checkOutput("idle_A_busy", 64'(ifA.busy), 64'd0);
        checkOutput("idle_B_busy", 64'(ifB.busy), 64'd0);

        // Start job 0x5A: no grant on the start edge, then one grant per cycle.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 8'hFF);
        tick();
        checkOutput("start_A_busy",  64'(ifA.busy), 64'd1);
        checkOutput("start_A_grant", 64'(ifA.core_grant), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 8'hFF);
        for (int k = 0; k < 10; k++) pushA(k % 8, k, 8'h5A);
        repeat (10) tick();
        expectDrained("allreq_drained");

        // Sparse requests on cores 2,5,7 starting from rr=2 with core1 masked.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 8'b1010_0100);
        pushA(2, 10, 8'h5A);
        pushA(5, 11, 8'h5A);
        pushA(7, 12, 8'h5A);
        pushA(2, 13, 8'h5A);
        pushA(5, 14, 8'h5A);
        repeat (5) tick();
        expectDrained("sparse_drained");
        checkOutput("sparse_issued", 64'(ifA.chunks_issued), 64'd15);

        // Abort with requests pending: straight to IDLE, nothing granted.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 8'hFF);
        tick();
        checkOutput("abort_busy",  64'(ifA.busy), 64'd0);
        checkOutput("abort_grant", 64'(ifA.core_grant), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 8'hFF);
        repeat (2) tick();
        checkOutput("abort_idle_busy", 64'(ifA.busy), 64'd0);
        checkOutput("abort_issued",    64'(ifA.chunks_issued), 64'd15);

        // New job 0x77, then start+solved together: restart wins.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h77, 8'hFF);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h77, 8'hFF);
        for (int k = 0; k < 3; k++) pushA(k, k, 8'h77);
        repeat (3) tick();
        expectDrained("job77_drained");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'hC3, 8'hFF);
        tick();
        checkOutput("restart_grant",  64'(ifA.core_grant), 64'd0);
        checkOutput("restart_busy",   64'(ifA.busy), 64'd1);
        checkOutput("restart_issued", 64'(ifA.chunks_issued), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'hC3, 8'hFF);
        pushA(0, 0, 8'hC3);
        tick();
        expectDrained("restart_drained");

        // Solution alone ends the job.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'hC3, 8'hFF);
        tick();
        checkOutput("solved_busy", 64'(ifA.busy), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'hC3, 8'hFF);
        tick();

        // Reset while a grant is on the outputs clears everything at once.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 8'hFF);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 8'hFF);
        pushA(0, 0, 8'h11);
        tick();
        expectDrained("midrst_granted");
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_grant",  64'(ifA.core_grant), 64'd0);
        checkOutput("midrst_busy",   64'(ifA.busy), 64'd0);
        checkOutput("midrst_issued", 64'(ifA.chunks_issued), 64'd0);
        checkOutput("midrst_end",    64'(ifA.grant_nonce_end), 64'd0);
        checkOutput("midrst_jobid",  64'(ifA.grant_job_id), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("postrst_busy", 64'(ifA.busy), 64'd0);

        // Instance B: single core, grants every other cycle, 16 chunks total.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, 8'h01);
        tick();
        checkOutput("B_start_busy", 64'(ifB.busy), 64'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h01);
        for (int k = 0; k < 16; k++) begin
            pushB(k, 8'h3C);
            tick();
            expectDrained("B_grant_arrived");
            if (k < 15) begin
                tick();
                checkOutput("B_masked_gap", 64'(ifB.core_grant), 64'd0);
            end
        end
        checkOutput("B_exhausted", 64'(ifB.exhausted), 64'd1);
        checkOutput("B_busy_off",  64'(ifB.busy), 64'd0);
        repeat (4) tick();
        checkOutput("B_exh_hold",   64'(ifB.exhausted), 64'd1);
        checkOutput("B_issued_end", 64'(ifB.chunks_issued), 64'd16);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 8'h01);
        tick();
        checkOutput("B_solved_exh", 64'(ifB.exhausted), 64'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h01);
        tick();

        expectDrained("final_drained");
        $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
        $finish;
    end

endmodule
